// File: rtl/activation_sequencer_pkg.sv
// Shared definitions for the activation sequencer: default data width,
// FSM state encoding and the vector element slice helper.
package activation_sequencer_pkg;

  localparam int ACT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

  // Element i of a packed vector lives at [elem_lsb(i, W) +: W].
  function automatic int elem_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/activation_sequencer.sv
// Time-multiplexes one external combinational activation unit across a layer:
// latches z_vector, issues one z per cycle, captures results, publishes atomically.
module activation_sequencer
  import activation_sequencer_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int DATA_WIDTH  = ACT_DATA_WIDTH,
  parameter int IDX_WIDTH   = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] z_vector,
  output logic                              busy,
  output logic                              done,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0] a_vector,
  output logic [DATA_WIDTH-1:0]             act_z,
  input  logic [DATA_WIDTH-1:0]             act_a
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

  seq_state_e r_state;
  seq_state_e w_next_state;
  logic       w_accept;
  logic       w_issue;
  logic       w_drain;

  logic [IDX_WIDTH-1:0]          r_issue_idx;
  logic [IDX_WIDTH-1:0]          r_cap_idx;
  logic                          r_cap_valid;
  logic signed [DATA_WIDTH-1:0]  r_z_buf [NUM_NEURONS];
  logic signed [DATA_WIDTH-1:0]  r_a_buf [NUM_NEURONS];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = ST_RUN;
      ST_RUN:   if (r_issue_idx == LAST_IDX) w_next_state = ST_DRAIN;
      ST_DRAIN: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_accept = (r_state == ST_IDLE) && start;
    w_issue  = (r_state == ST_RUN);
    w_drain  = (r_state == ST_DRAIN);
  end

  assign busy = (r_state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue_idx <= '0;
      r_cap_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= w_drain;
      if (w_accept) begin
        r_issue_idx <= '0;
        r_cap_valid <= 1'b0;
      end
      if (w_issue) begin
        r_cap_valid <= 1'b1;
        if (r_issue_idx != LAST_IDX) r_issue_idx <= r_issue_idx + IDX_WIDTH'(1);
      end
      if (w_drain) r_cap_valid <= 1'b0;
    end
  end

  // Input latch: z_vector is free to change once accepted.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_z_buf[i] <= z_vector[elem_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  // Issue stage: operand to the shared unit, index of the value in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_z <= '0;
    end else if (w_issue) begin
      act_z <= r_z_buf[r_issue_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) r_cap_idx <= r_issue_idx;
  end

  // Capture stage: result for the operand issued on the previous edge.
  always_ff @(posedge clk) begin
    if (w_issue && r_cap_valid) r_a_buf[r_cap_idx] <= act_a;
  end

  // Publish: last element comes straight from the unit, so no extra cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_vector <= '0;
    end else if (w_drain) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        a_vector[elem_lsb(i, DATA_WIDTH) +: DATA_WIDTH] <=
          (i == NUM_NEURONS - 1) ? act_a : r_a_buf[i];
      end
    end
  end

endmodule

// File: tb/tb_activation_sequencer.sv
// Bench for activation_sequencer: three instances (N=4, 2, 7) each with a
// +1 wrapping stub as the shared activation unit.
module tb_activation_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        s4_start = 1'b0, s4_busy, s4_done;
  logic [31:0] s4_z = '0, s4_a;
  logic [7:0]  s4_act_z, s4_act_a;
  logic        s2_start = 1'b0, s2_busy, s2_done;
  logic [15:0] s2_z = '0, s2_a;
  logic [7:0]  s2_act_z, s2_act_a;
  logic        s7_start = 1'b0, s7_busy, s7_done;
  logic [55:0] s7_z = '0, s7_a;
  logic [7:0]  s7_act_z, s7_act_a;

  assign s4_act_a = s4_act_z + 8'd1;
  assign s2_act_a = s2_act_z + 8'd1;
  assign s7_act_a = s7_act_z + 8'd1;

  activation_sequencer #(.NUM_NEURONS(4), .DATA_WIDTH(8), .IDX_WIDTH(2)) u_dut4 (
    .clk(clk), .rst(rst), .start(s4_start), .z_vector(s4_z), .busy(s4_busy),
    .done(s4_done), .a_vector(s4_a), .act_z(s4_act_z), .act_a(s4_act_a));
  activation_sequencer #(.NUM_NEURONS(2), .DATA_WIDTH(8), .IDX_WIDTH(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(s2_start), .z_vector(s2_z), .busy(s2_busy),
    .done(s2_done), .a_vector(s2_a), .act_z(s2_act_z), .act_a(s2_act_a));
  activation_sequencer #(.NUM_NEURONS(7), .DATA_WIDTH(8), .IDX_WIDTH(3)) u_dut7 (
    .clk(clk), .rst(rst), .start(s7_start), .z_vector(s7_z), .busy(s7_busy),
    .done(s7_done), .a_vector(s7_a), .act_z(s7_act_z), .act_a(s7_act_a));

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] z;
    logic [31:0] a;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: every element passes through the +1 stub independently.
  function automatic logic [55:0] model(input int n, input logic [55:0] z);
    logic [55:0] r = '0;
    for (int i = 0; i < n; i++) r[i*8 +: 8] = z[i*8 +: 8] + 8'd1;
    return r;
  endfunction

  function automatic logic [55:0] get_a(input int n);
    case (n)
      2:       return 56'(s2_a);
      4:       return 56'(s4_a);
      default: return s7_a;
    endcase
  endfunction

  function automatic logic get_done(input int n);
    case (n)
      2:       return s2_done;
      4:       return s4_done;
      default: return s7_done;
    endcase
  endfunction

  function automatic logic get_busy(input int n);
    case (n)
      2:       return s2_busy;
      4:       return s4_busy;
      default: return s7_busy;
    endcase
  endfunction

  function automatic logic [7:0] get_actz(input int n);
    case (n)
      2:       return s2_act_z;
      4:       return s4_act_z;
      default: return s7_act_z;
    endcase
  endfunction

  task automatic drive(input int n, input logic s, input logic [55:0] z);
    case (n)
      2:       begin s2_start = s; s2_z = z[15:0]; end
      4:       begin s4_start = s; s4_z = z[31:0]; end
      default: begin s7_start = s; s7_z = z; end
    endcase
  endtask

  // Starts one vector from the current cycle and follows it to done.
  task automatic run_vec(input int n, input logic [55:0] z, input bit lockout,
                         input bit chaos, input bit post, input string tag,
                         output logic [55:0] a_got);
    logic [55:0] exp_a, a_prev, seq, zd;
    logic [63:0] mask;
    int lat, busy_n;
    bit changed, got_done;
    mask   = (64'd1 << (n * 8)) - 64'd1;
    exp_a  = model(n, z);
    a_prev = get_a(n);
    drive(n, 1'b1, z);
    tick();
    lat = -1; busy_n = 0; seq = '0; changed = 0; got_done = 0;
    for (int c = 0; c < 3 * n + 10 && !got_done; c++) begin
      if (get_busy(n)) busy_n++;
      if (c >= 1 && c <= n) seq[(c-1)*8 +: 8] = get_actz(n);
      if (get_done(n)) begin
        got_done = 1;
        lat = c;
      end else begin
        if (get_a(n) !== a_prev) changed = 1;
        zd = chaos ? {56{1'b1}} : (lockout ? ~z : z);
        drive(n, lockout && c >= 1 && c <= 3, zd);
        tick();
      end
    end
    drive(n, 1'b0, z);
    a_got = get_a(n);
    check({tag, "_done_seen"}, 64'(got_done), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(n + 1));
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(n + 1));
    check({tag, "_act_z_order"}, 64'(seq) & mask, 64'(z) & mask);
    check({tag, "_a_vector"}, 64'(a_got) & mask, 64'(exp_a) & mask);
    check({tag, "_a_held_until_done"}, 64'(changed), 64'd0);
    if (post) begin
      tick();
      check({tag, "_single_done"}, 64'(get_done(n)), 64'd0);
      check({tag, "_idle_after"}, 64'(get_busy(n)), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl [5];
    logic [55:0] a_got, z;
    int          ndone, nbusy;

    tbl[0] = '{z: 32'hF0807F10, a: 32'hF1818011};
    tbl[1] = '{z: 32'h00000000, a: 32'h01010101};
    tbl[2] = '{z: 32'h04030201, a: 32'h05040302};
    tbl[3] = '{z: 32'hFFFFFFFF, a: 32'h00000000};
    tbl[4] = '{z: 32'h7F7F807F, a: 32'h80808180};

    tick();
    tick();
    check("reset_busy", 64'(s4_busy), 64'd0);
    check("reset_done", 64'(s4_done), 64'd0);
    check("reset_act_z", 64'(s4_act_z), 64'd0);
    check("reset_a_vector", 64'(s4_a), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_vec(4, 56'(tbl[i].z), 0, 0, 1, $sformatf("tbl%0d", i), a_got);
      check($sformatf("tbl%0d_expected", i), 64'(a_got), 64'(tbl[i].a));
    end

    run_vec(4, 56'(tbl[0].z), 1, 0, 1, "lockout", a_got);
    check("lockout_result", 64'(a_got), 64'(tbl[0].a));

    // Back-to-back: second start sits in the done cycle of the first.
    run_vec(4, 56'(tbl[0].z), 0, 0, 0, "b2b_first", a_got);
    run_vec(4, 56'h0, 0, 0, 1, "b2b_second", a_got);
    check("b2b_second_result", 64'(a_got), 64'h01010101);

    // Mid-operation reset after issue 2, with a start in the reset cycle.
    s4_start = 1'b1; s4_z = 32'h0A0B0C0D;
    tick();
    s4_start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; s4_start = 1'b1; s4_z = 32'h11111111;
    tick();
    rst = 1'b0; s4_start = 1'b0;
    check("midrst_busy", 64'(s4_busy), 64'd0);
    check("midrst_a_vector", 64'(s4_a), 64'd0);
    check("midrst_act_z", 64'(s4_act_z), 64'd0);
    ndone = 0; nbusy = 0;
    for (int c = 0; c < 8; c++) begin
      if (s4_done) ndone++;
      if (s4_busy) nbusy++;
      tick();
    end
    check("midrst_no_done", 64'(ndone), 64'd0);
    check("midrst_start_ignored", 64'(nbusy), 64'd0);
    run_vec(4, 56'h04030201, 0, 0, 1, "midrst_restart", a_got);
    check("midrst_restart_result", 64'(a_got), 64'h05040302);

    run_vec(4, 56'hC3B2A190, 0, 1, 1, "stability", a_got);
    check("stability_result", 64'(a_got), 64'hC4B3A291);

    for (int r = 0; r < 16; r++) begin
      z = 56'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      run_vec(4, z, r[0], r[1], 1, $sformatf("rnd%0d", r), a_got);
    end

    run_vec(2, 56'h0201, 0, 0, 1, "n2_inc", a_got);
    check("n2_inc_result", 64'(a_got), 64'h0302);
    run_vec(7, 56'h07060504030201, 0, 0, 1, "n7_inc", a_got);
    check("n7_inc_result", 64'(a_got), 64'h08070605040302);
    for (int r = 0; r < 3; r++) begin
      z = {$urandom, $urandom};
      run_vec(2, z, 0, r[0], 1, $sformatf("n2_rnd%0d", r), a_got);
      run_vec(7, z, 0, r[0], 1, $sformatf("n7_rnd%0d", r), a_got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
